// File: rtl/chaos_pkg.sv
// rtl/chaos_pkg.sv - shared chaos cipher constants, FSM states and keystream helpers
package chaos_pkg;

  localparam int          Q16_W        = 16;
  localparam logic [15:0] SALT_DEFAULT = 16'h5A5A;
  localparam logic [7:0]  ZERO_PAD     = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Keystream byte folded out of the Q16 map state.
  function automatic logic [7:0] ks_of(input logic [Q16_W-1:0] x);
    return x[15:8] ^ x[7:0];
  endfunction

  // One step of the Q16 logistic map with r=4: x*(1-x)*4 in Q16 is x*(2^16-x) >> 14.
  // The top of the range saturates; a collapse to zero is re-seeded from the key.
  function automatic logic [Q16_W-1:0] map_next(input logic [Q16_W-1:0] x,
                                                input logic [7:0]       key_k);
    logic [32:0] xa;
    logic [32:0] xb;
    logic [32:0] t;
    xa = {17'd0, x};
    xb = 33'h1_0000 - xa;
    t  = (xa * xb) >> 14;
    if (t >= 33'h1_0000) begin
      return 16'hFFFF;
    end else if (t[15:0] == 16'h0000) begin
      return {key_k, ZERO_PAD};
    end else begin
      return t[15:0];
    end
  endfunction

endpackage

// File: rtl/chaos_encrypt_stream_keystream.sv
// rtl/chaos_encrypt_stream_keystream.sv - chaotic map state register producing the keystream byte
// Ports: seed_load loads seed (zero replaced by 1), step advances the map,
// key_k feeds the zero-collapse guard, ks is the current keystream byte.
module chaos_keystream
  import chaos_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic [7:0]  key_k,
  input  logic        step,
  output logic [7:0]  ks
);

  logic [15:0] x_q;
  logic [15:0] x_d;

  always_comb begin
    x_d = x_q;
    if (seed_load) begin
      // A zero seed would be a fixed point of the map.
      x_d = (seed == 16'h0000) ? 16'h0001 : seed;
    end else if (step) begin
      x_d = map_next(x_q, key_k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= 16'h0000;
    end else begin
      x_q <= x_d;
    end
  end

  assign ks = ks_of(x_q);

endmodule

// File: rtl/chaos_encrypt_stream.sv
// rtl/chaos_encrypt_stream.sv - streaming chaotic-keystream pixel encryptor with ciphertext chaining
// Ports: start/key_k/key_f begin a frame; s_valid/s_data/s_ready plaintext in;
// m_valid/m_data/m_last/m_ready ciphertext out; busy spans the frame, done pulses at its end.
module chaos_encrypt_stream
  import chaos_pkg::*;
#(
  parameter int          IMG_W = 256,
  parameter int          IMG_H = 256,
  parameter logic [15:0] SALT  = SALT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] key_k,
  input  logic [7:0] key_f,
  output logic       busy,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  state_e          state_q, state_d;
  logic [7:0]      kk_q, kf_q;
  logic [7:0]      c_prev_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic            m_valid_q;
  logic [7:0]      m_data_q;
  logic            m_last_q;

  logic            accept;
  logic            start_ok;
  logic            col_end;
  logic            last_pix;
  logic [7:0]      ks;
  logic [7:0]      cipher;

  assign start_ok = start && (state_q == ST_IDLE);
  assign accept   = s_valid && s_ready;
  assign col_end  = (col_q == CW'(IMG_W - 1));
  assign last_pix = col_end && (row_q == RW'(IMG_H - 1));
  assign cipher   = (s_data + ks) ^ c_prev_q;

  chaos_keystream u_keystream (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (state_q == ST_SEED),
    .seed      ({kk_q, kf_q} ^ SALT),
    .key_k     (kk_q),
    .step      (accept),
    .ks        (ks)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)                     state_d = ST_SEED;
      ST_SEED:                                 state_d = ST_RUN;
      ST_RUN:   if (accept && last_pix)        state_d = ST_DRAIN;
      ST_DRAIN: if (!m_valid_q || m_ready)     state_d = ST_DONE;
      ST_DONE:                                 state_d = ST_IDLE;
      default:                                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    s_ready = (state_q == ST_RUN) && (!m_valid_q || m_ready);
  end

  // Keys are captured at start so later changes on the pins cannot disturb the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kk_q      <= 8'h00;
      kf_q      <= 8'h00;
      c_prev_q  <= 8'h00;
      col_q     <= '0;
      row_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
      m_last_q  <= 1'b0;
    end else begin
      if (start_ok) begin
        kk_q <= key_k;
        kf_q <= key_f;
      end
      if (state_q == ST_SEED) begin
        c_prev_q <= kf_q;
        col_q    <= '0;
        row_q    <= '0;
      end
      if (accept) begin
        c_prev_q  <= cipher;
        m_data_q  <= cipher;
        m_last_q  <= last_pix;
        m_valid_q <= 1'b1;
        if (col_end) begin
          col_q <= '0;
          if (!last_pix) row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_chaos_encrypt_stream.sv
// tb/tb_chaos_encrypt_stream.sv - directed self-checking bench for chaos_encrypt_stream
module tb_chaos_encrypt_stream;

  localparam int W      = 8;
  localparam int H      = 4;
  localparam int N      = W * H;
  localparam int BUDGET = 2000;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] key_k;
  logic [7:0] key_f;
  logic       busy;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;
  logic       done;

  int         n_assert;
  int         n_fail;
  logic [7:0] pin  [N];
  logic [7:0] cout [N];
  logic [7:0] cref [N];

  chaos_encrypt_stream #(.IMG_W(W), .IMG_H(H), .SALT(16'h5A5A)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .key_k   (key_k),
    .key_f   (key_f),
    .busy    (busy),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_ready (m_ready),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mdl_map(input logic [15:0] x, input logic [7:0] k);
    longint t;
    t = (longint'(x) * (65536 - longint'(x))) >>> 14;
    if (t >= 65536) return 16'hFFFF;
    if (t == 0) return {k, 8'hA5};
    return 16'(t);
  endfunction

  // mode 0: m_ready high; 1: random m_ready/s_valid; 2: 10-cycle stall after first accept;
  // 3: m_ready high with a stray start and key_k change mid-frame.
  task automatic run_frame(input logic [7:0] k, input logic [7:0] f, input int mode);
    int         nin, nout, ndone, stall;
    logic [7:0] prev_data, cp, ksm, p;
    logic       prev_stall;
    logic [15:0] x;
    nin = 0; nout = 0; ndone = 0; stall = 0; prev_stall = 1'b0; prev_data = 8'h00;
    @(negedge clk);
    start = 1'b1; key_k = k; key_f = f;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < BUDGET && ndone == 0; cyc++) begin
      start = 1'b0;
      case (mode)
        1: m_ready = 1'($urandom_range(0, 1));
        2: if (nin >= 1 && stall < 10) begin m_ready = 1'b0; stall++; end else m_ready = 1'b1;
        3: begin
             m_ready = 1'b1;
             if (cyc == 12) begin start = 1'b1; key_k = ~k; end
           end
        default: m_ready = 1'b1;
      endcase
      s_valid = (nin < N) && (mode != 1 || $urandom_range(0, 3) != 0);
      s_data  = (nin < N) ? pin[nin] : 8'h00;
      #1;
      if (prev_stall) chk("hold_data", 32'(m_data), 32'(prev_data));
      if (m_valid && !m_ready) chk("stall_s_ready", 32'(s_ready), 32'd0);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (done) ndone++;
      if (m_valid && m_ready) begin
        if (nout < N) begin
          cout[nout] = m_data;
          chk("m_last", 32'(m_last), 32'(nout == N - 1));
        end
        nout++;
      end
      if (s_valid && s_ready) nin++;
      @(negedge clk);
    end
    s_valid = 1'b0; start = 1'b0; m_ready = 1'b0; key_k = k;
    #1;
    chk("out_count", 32'(nout), 32'(N));
    chk("done_pulses", 32'(ndone), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    x  = {k, f} ^ 16'h5A5A;
    if (x == 16'h0000) x = 16'h0001;
    cp = f;
    for (int i = 0; i < N; i++) begin
      ksm = x[15:8] ^ x[7:0];
      p   = (cout[i] ^ cp) - ksm;
      chk("decrypt", 32'(p), 32'(pin[i]));
      cp = cout[i];
      x  = mdl_map(x, k);
    end
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; key_k = 8'h00; key_f = 8'h00;
    s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    s_valid = 1'b1; m_ready = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("idle_s_ready", 32'(s_ready), 32'd0);

    // K=0,F=0, p=0x10: c0=0x10 one cycle after accept, c1=0x53
    @(negedge clk);
    start = 1'b1; key_k = 8'h00; key_f = 8'h00;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = 8'h10; m_ready = 1'b1;
    #1;
    chk("seed_busy", 32'(busy), 32'd1);
    chk("seed_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("run_s_ready", 32'(s_ready), 32'd1);
    chk("pre_m_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("lat_m_valid", 32'(m_valid), 32'd1);
    chk("c0", 32'(m_data), 32'h10);
    chk("c0_last", 32'(m_last), 32'd0);
    @(negedge clk);
    #1;
    chk("c1", 32'(m_data), 32'h53);

    // Mid-frame reset aborts asynchronously
    rst_n = 1'b0;
    #1;
    chk("abort_m_valid", 32'(m_valid), 32'd0);
    chk("abort_m_data", 32'(m_data), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    #1 chk("abort_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // Restart with the same key reproduces the first ciphertexts
    for (int i = 0; i < N; i++) pin[i] = 8'h10;
    run_frame(8'h00, 8'h00, 0);
    chk("restart_c0", 32'(cout[0]), 32'h10);
    chk("restart_c1", 32'(cout[1]), 32'h53);

    // Seed 0x8000: x saturates to 0xFFFF then falls to 0x0003, 0x000B
    for (int i = 0; i < N; i++) pin[i] = 8'h00;
    run_frame(8'hDA, 8'h5A, 0);
    chk("sat_c0", 32'(cout[0]), 32'hDA);
    chk("sat_c1", 32'(cout[1]), 32'hDA);
    chk("sat_c2", 32'(cout[2]), 32'hD9);
    chk("sat_c3", 32'(cout[3]), 32'hD2);

    // Zero seed is replaced by 1
    run_frame(8'h5A, 8'h5A, 0);
    chk("zseed_c0", 32'(cout[0]), 32'h5B);
    chk("zseed_c1", 32'(cout[1]), 32'h58);

    // Random pixels with random backpressure
    for (int i = 0; i < N; i++) pin[i] = 8'($urandom);
    run_frame(8'h3C, 8'h77, 1);

    // Ten-cycle stall
    for (int i = 0; i < N; i++) pin[i] = 8'(i * 7 + 3);
    run_frame(8'hC3, 8'h11, 2);

    // Stray start and key change mid-frame leave the output unchanged
    for (int i = 0; i < N; i++) pin[i] = 8'($urandom);
    run_frame(8'h5E, 8'hE1, 0);
    for (int i = 0; i < N; i++) cref[i] = cout[i];
    run_frame(8'h5E, 8'hE1, 3);
    for (int i = 0; i < N; i++) chk("disturb_same", 32'(cout[i]), 32'(cref[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
